// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types, FSM encoding and byte-placement helpers
// for the byte-serial round datapath.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    // Element 15 holds byte 0 (the most significant byte of the bus).
    typedef logic [AES_NBYTES-1:0][7:0] state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // Byte i = r + 4c moves to column (c - r) mod 4 of the same row.
    function automatic logic [3:0] shiftrows_dst(input logic [3:0] i);
        return {i[3:2] - i[1:0], i[1:0]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p ^= b[k] ? x : 8'h00;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/SubB.sv
// SubB: combinational AES S-box; multiplicative inverse as x^254, then the
// FIPS-197 affine map.
module SubB
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero for free
    always_comb begin
        logic [7:0] t;
        t   = a_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
    end

    assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/sub_shift_serial.sv
// sub_shift_serial: byte-serial AES SubBytes(+ShiftRows) stage, LANES S-boxes per cycle.
// Define SUBSHIFT_SHIFTROWS_EN for ShiftRows placement; otherwise bytes keep their index.
module sub_shift_serial
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int NCYC = AES_NBYTES / LANES;
    localparam int CW   = NCYC > 1 ? $clog2(NCYC) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_shift_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t          state_q;
    logic [CW-1:0] cnt_q;
    state_t        cap_q;
    state_t        res_q;
    logic [7:0]    sb_out [LANES];
    logic [3:0]    dst    [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] idx;
        assign idx = 4'(int'(cnt_q) * LANES + l);
`ifdef SUBSHIFT_SHIFTROWS_EN
        assign dst[l] = shiftrows_dst(idx);
`else
        assign dst[l] = idx;
`endif
        SubB u_subb (
            .a_i (cap_q[~idx]),
            .s_o (sb_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    cap_q   <= in_data;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) res_q[~dst[k]] <= sb_out[k];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NCYC - 1)) state_q <= DONE;
                end
                DONE: if (out_ready) begin
                    // a waiting state is taken in the same cycle the result leaves
                    state_q <= in_valid ? RUN : IDLE;
                    if (in_valid) begin
                        cap_q <= in_data;
                        cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = state_q == DONE;
    assign out_data  = res_q;
    assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_sub_shift_serial.sv
// tb_sub_shift_serial: random and directed checks of sub_shift_serial for LANES 1, 4 and 16
// against a table-based AES model; follows SUBSHIFT_SHIFTROWS_EN like the RTL.
module tb_sub_shift_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_t [256];
    int         log_t [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_shift_serial #(.LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Antilog/log tables over generator 3 give inverses without any multiplier.
    function automatic void build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
        end
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c   = 8'h63;
        inv = (b == 0) ? 8'h00 : exp_t[(255 - log_t[b]) % 255];
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] o;
        int r, c, d;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
`ifdef SUBSHIFT_SHIFTROWS_EN
            d = r + 4 * ((c - r + 4) % 4);
`else
            d = i;
`endif
            o[127 - 8 * d -: 8] = sbox(st[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic int ncyc(input int d);
        return d == 0 ? 16 : (d == 1 ? 4 : 1);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int d, input logic [127:0] st);
        int n;
        n = 0;
        in_data[d]  = st;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 128'(in_ready[d]), 128'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = rand128();
    endtask

    task automatic wait_out(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic xact(input int d, input logic [127:0] st, input string tag, output logic [127:0] res);
        int lat;
        out_ready[d] = 1'b1;
        send(d, st);
        wait_out(d, lat);
        chk({tag, "_lat"}, 128'(lat), 128'(ncyc(d)));
        res = out_data[d];
        chk(tag, res, model(st));
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, 128'(out_valid[d]), 128'd0);
    endtask

    task automatic stream(input int d);
        logic [127:0] st [4];
        int nin, nout, cyc, last;
        bit hs;
        nin = 0; nout = 0; cyc = 0; last = 0;
        for (int k = 0; k < 4; k++) st[k] = rand128();
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        in_data[d]   = st[0];
        while (nout < 4 && cyc < 400) begin
            @(negedge clk);
            if (out_valid[d]) begin
                chk("stream_data", out_data[d], model(st[nout]));
                if (nout > 0) chk("stream_gap", 128'(cyc - last), 128'(ncyc(d) + 1));
                last = cyc;
                nout++;
            end
            hs = in_valid[d] && in_ready[d];
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                nin++;
                if (nin < 4) in_data[d] = st[nin];
                else in_valid[d] = 1'b0;
            end
        end
        chk("stream_count", 128'(nout), 128'd4);
        in_valid[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res, a, b, held;
        int lat;
        build_tables();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in_data[d]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_out_data", out_data[0], 128'd0);
        chk("rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xact(0, 128'd0, "zero", res);
        chk("zero_const", res, {16{8'h63}});

        xact(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips", res);
`ifdef SUBSHIFT_SHIFTROWS_EN
        chk("fips_const", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
`else
        chk("fips_const", res, 128'hd42711aee0bf98f1b8b45de51e415230);
`endif

        xact(0, {8'h53, 120'd0}, "single", res);
        chk("single_const", res, {8'hed, {15{8'h63}}});

        // Backpressure: result held while out_ready is low, inputs ignored
        a = rand128();
        b = rand128();
        out_ready[0] = 1'b0;
        send(0, a);
        wait_out(0, lat);
        chk("bp_lat", 128'(lat), 128'd16);
        held = out_data[0];
        chk("bp_data", held, model(a));
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'($urandom);
            in_data[0]  = rand128();
            @(negedge clk);
            chk("bp_hold_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_hold_data", out_data[0], held);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
            @(posedge clk);
            #1;
        end
        in_valid[0]  = 1'b1;
        in_data[0]   = b;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        in_data[0]  = rand128();
        chk("bp_next_busy", 128'(busy[0]), 128'd1);
        chk("bp_next_valid", 128'(out_valid[0]), 128'd0);
        wait_out(0, lat);
        chk("bp_next_lat", 128'(lat), 128'd16);
        chk("bp_next_data", out_data[0], model(b));
        @(posedge clk);
        #1;

        // Reset while cnt==7
        send(0, rand128());
        repeat (7) @(posedge clk);
        #1;
        chk("mid_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_out_data", out_data[0], 128'd0);
        chk("mid_rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xact(0, rand128(), "after_rst", res);

        for (int d = 0; d < 3; d++) stream(d);
        xact(1, 128'd0, "zero_l4", res);
        xact(2, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips_l16", res);
        xact(1, {8'h53, 120'd0}, "single_l4", res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
